// File: rtl/inv_mix_columns_if.sv
// Block handshake and data bus for the AES inverse-mix-columns stage.
// The round controller uses the master modport; the stage uses the slave modport.
interface inv_mix_columns_if;
    logic             new_block_in;
    logic             bypass_in;
    logic [15:0][7:0] block_in;
    logic [15:0][7:0] inv_mixed_block_out;
    logic             valid_out;
    logic             ready_out;

    modport master (
        output new_block_in,
        output bypass_in,
        output block_in,
        input  inv_mixed_block_out,
        input  valid_out,
        input  ready_out
    );

    modport slave (
        input  new_block_in,
        input  bypass_in,
        input  block_in,
        output inv_mixed_block_out,
        output valid_out,
        output ready_out
    );
endinterface

// File: rtl/inv_mix_columns.sv
// AES InvMixColumns on a 128-bit block, one 4-byte column per cycle.
// When bypass is set, the block passes through unchanged with the same latency.
module inv_mix_columns (
    input  logic               clk_in,
    input  logic               rst_n_in,
    inv_mix_columns_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COLUMN = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [1:0]       col;
    logic [15:0][7:0] saved_block;
    logic             saved_bypass;
    logic [15:0][7:0] internal;
    logic [3:0][7:0]  col_in;
    logic [3:0][7:0]  col_result;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Coefficients 09/0b/0d/0e are formed from the x2, x4, x8 xtime chain.
    function automatic logic [3:0][7:0] inv_column(input logic [3:0][7:0] a);
        logic [3:0][7:0] m9, mb, md, me;
        logic [7:0]      x2, x4, x8;
        logic [3:0][7:0] r;
        for (int i = 0; i < 4; i++) begin
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        r[0] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
        r[1] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
        r[2] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
        r[3] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
        return r;
    endfunction

    assign col_in     = saved_block[{col, 2'b00} +: 4];
    assign col_result = saved_bypass ? col_in : inv_column(col_in);

    assign bus.ready_out = (state == IDLE);

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.new_block_in) state_next = COLUMN;
            COLUMN:  if (col == 2'd3) state_next = OUTPUT;
            OUTPUT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath registers; the last column goes straight to the output register.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            col                     <= 2'd0;
            saved_block             <= '0;
            saved_bypass            <= 1'b0;
            internal                <= '0;
            bus.inv_mixed_block_out <= '0;
            bus.valid_out           <= 1'b0;
        end else begin
            bus.valid_out <= (state == COLUMN) && (col == 2'd3);
            case (state)
                IDLE: begin
                    if (bus.new_block_in) begin
                        saved_block  <= bus.block_in;
                        saved_bypass <= bus.bypass_in;
                        col          <= 2'd0;
                    end
                end
                COLUMN: begin
                    if (col != 2'd3) begin
                        internal[{col, 2'b00} +: 4] <= col_result;
                        col                         <= col + 2'd1;
                    end else begin
                        bus.inv_mixed_block_out <= {col_result, internal[11:0]};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inv_mix_columns.sv
// Self-checking bench for inv_mix_columns against a GF(2^8) matrix-multiply model.
module tb_inv_mix_columns;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    inv_mix_columns_if bus();

    inv_mix_columns dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] FIPS_IN  = 128'hf8bd7e4d_d6d7d5d5_9d58dc9f_bca14d8e;
    localparam logic [127:0] FIPS_OUT = 128'h4c31262d_d5d4d4d4_5c220af2_455313db;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // Circulant matrix times each state column; row0 coefficients given.
    function automatic logic [15:0][7:0] circ(input logic [15:0][7:0] b,
                                              input logic [31:0] row0);
        logic [15:0][7:0] r;
        logic [3:0][7:0]  coef;
        coef = row0;
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++) begin
                r[4*c+rr] = 8'h00;
                for (int k = 0; k < 4; k++)
                    r[4*c+rr] ^= gmul(coef[(k - rr + 4) % 4], b[4*c+k]);
            end
        return r;
    endfunction

    function automatic logic [15:0][7:0] ref_inv_mix(input logic [15:0][7:0] b);
        return circ(b, 32'h090d0b0e);
    endfunction

    function automatic logic [15:0][7:0] ref_mix(input logic [15:0][7:0] b);
        return circ(b, 32'h01010302);
    endfunction

    function automatic logic [15:0][7:0] rand_block();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic accept(input logic [15:0][7:0] blk, input logic byp);
        @(negedge clk);
        vectors++;
        if (bus.ready_out !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL accept_ready: ready_out=%b required 1", bus.ready_out);
        end
        bus.new_block_in = 1'b1;
        bus.block_in     = blk;
        bus.bypass_in    = byp;
        @(negedge clk);
        bus.new_block_in = 1'b0;
        bus.block_in     = rand_block();
        bus.bypass_in    = $urandom_range(0, 1);
    endtask

    task automatic await_result(input string name, input logic [15:0][7:0] exp);
        int k;
        k = 0;
        while (k < 12) begin
            @(negedge clk);
            k++;
            if (bus.valid_out === 1'b1) break;
        end
        vectors++;
        if (k != 4 || bus.valid_out !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL %s_latency: valid after %0d cycles, required 4", name, k);
        end
        vectors++;
        if (bus.inv_mixed_block_out !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s_data: got %h required %h", name, bus.inv_mixed_block_out, exp);
        end
        @(negedge clk);
        vectors++;
        if (bus.valid_out !== 1'b0 || bus.ready_out !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL %s_pulse: valid=%b ready=%b required valid=0 ready=1",
                     name, bus.valid_out, bus.ready_out);
        end
    endtask

    task automatic test_reset();
        int pulses;
        rst_n            = 1'b0;
        bus.new_block_in = 1'b1;
        bus.bypass_in    = 1'b0;
        bus.block_in     = rand_block();
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.ready_out !== 1'b1 || bus.valid_out !== 1'b0 || bus.inv_mixed_block_out !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_state: ready=%b valid=%b out=%h required 1 0 0",
                     bus.ready_out, bus.valid_out, bus.inv_mixed_block_out);
        end
        bus.new_block_in = 1'b0;
        rst_n            = 1'b1;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.valid_out === 1'b1) pulses++;
        end
        vectors++;
        if (pulses != 0 || bus.inv_mixed_block_out !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_strobe_ignored: pulses=%0d out=%h required 0 0",
                     pulses, bus.inv_mixed_block_out);
        end
    endtask

    task automatic test_fips();
        accept(FIPS_IN, 1'b0);
        await_result("fips", FIPS_OUT);
    endtask

    task automatic test_fixed_points();
        logic [15:0][7:0] b;
        b = {16{8'h01}};
        accept(b, 1'b0);
        await_result("fixed_01", b);
        b = {16{8'hc6}};
        accept(b, 1'b0);
        await_result("fixed_c6", b);
    endtask

    task automatic test_bypass();
        logic [15:0][7:0] b;
        for (int i = 0; i < 16; i++) b[i] = 8'(i);
        accept(b, 1'b1);
        await_result("bypass", b);
    endtask

    task automatic test_back_to_back();
        logic [15:0][7:0] a, c;
        int pulses;
        logic ready_bad;
        a = rand_block();
        c = rand_block();
        accept(a, 1'b0);
        bus.new_block_in = 1'b1;
        bus.block_in     = rand_block();
        bus.bypass_in    = 1'b1;
        pulses    = 0;
        ready_bad = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (bus.valid_out === 1'b1) pulses++;
            if (k <= 4 && bus.ready_out !== 1'b0) ready_bad = 1'b1;
            if (k == 4) begin
                vectors++;
                if (bus.valid_out !== 1'b1 || bus.inv_mixed_block_out !== ref_inv_mix(a)) begin
                    miscompares++;
                    $display("[TB] FAIL busy_first: valid=%b out=%h required 1 %h",
                             bus.valid_out, bus.inv_mixed_block_out, ref_inv_mix(a));
                end
            end
            if (k == 5) begin
                vectors++;
                if (bus.ready_out !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL busy_ready_e5: ready=%b required 1", bus.ready_out);
                end
                bus.block_in  = c;
                bus.bypass_in = 1'b0;
            end
            if (k == 6) begin
                bus.new_block_in = 1'b0;
                bus.block_in     = rand_block();
            end
            if (k == 9) begin
                vectors++;
                if (pulses != 1 || ready_bad) begin
                    miscompares++;
                    $display("[TB] FAIL busy_ignore: pulses=%0d ready_bad=%b required 1 0",
                             pulses, ready_bad);
                end
            end
            if (k == 10) begin
                vectors++;
                if (bus.valid_out !== 1'b1 || bus.inv_mixed_block_out !== ref_inv_mix(c)) begin
                    miscompares++;
                    $display("[TB] FAIL busy_second_e10: valid=%b out=%h required 1 %h",
                             bus.valid_out, bus.inv_mixed_block_out, ref_inv_mix(c));
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_block();
        int pulses;
        accept(rand_block(), 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.valid_out !== 1'b0 || bus.inv_mixed_block_out !== '0 || bus.ready_out !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL midreset_state: valid=%b out=%h ready=%b required 0 0 1",
                     bus.valid_out, bus.inv_mixed_block_out, bus.ready_out);
        end
        rst_n  = 1'b1;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.valid_out === 1'b1) pulses++;
        end
        vectors++;
        if (pulses != 0) begin
            miscompares++;
            $display("[TB] FAIL midreset_no_valid: pulses=%0d required 0", pulses);
        end
        accept(FIPS_IN, 1'b0);
        await_result("midreset_fips", FIPS_OUT);
    endtask

    task automatic test_random();
        logic [15:0][7:0] b, exp;
        logic byp;
        for (int n = 0; n < 1000; n++) begin
            b   = rand_block();
            byp = ($urandom_range(0, 7) == 0);
            exp = byp ? b : ref_inv_mix(b);
            accept(b, byp);
            await_result("random", exp);
            if (!byp) begin
                vectors++;
                if (ref_mix(bus.inv_mixed_block_out) !== b) begin
                    miscompares++;
                    $display("[TB] FAIL random_roundtrip: mix(out)=%h required %h",
                             ref_mix(bus.inv_mixed_block_out), b);
                end
            end
        end
    endtask

    initial begin
        vectors          = 0;
        miscompares      = 0;
        rst_n            = 1'b0;
        bus.new_block_in = 1'b0;
        bus.bypass_in    = 1'b0;
        bus.block_in     = '0;
        test_reset();
        test_fips();
        test_fixed_points();
        test_bypass();
        test_back_to_back();
        test_reset_mid_block();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
